// File: rtl/pcpi_arbiter.sv
// pcpi_arbiter: registered fixed-priority PCPI fan-out / fan-in.
// Define PCPI_ARB_TIMEOUT_EN to build the hung co-processor watchdog.
module pcpi_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pcpi_valid_in,
  input  logic [31:0]            pcpi_insn_in,
  input  logic [31:0]            pcpi_rs1_in,
  input  logic [31:0]            pcpi_rs2_in,
  output logic                   pcpi_wr,
  output logic [31:0]            pcpi_rd,
  output logic                   pcpi_wait,
  output logic                   pcpi_ready,
  output logic [NUM_CH-1:0]      ch_valid,
  output logic [31:0]            ch_insn,
  output logic [31:0]            ch_rs1,
  output logic [31:0]            ch_rs2,
  input  logic [NUM_CH-1:0]      ch_wr,
  input  logic [32*NUM_CH-1:0]   ch_rd,
  input  logic [NUM_CH-1:0]      ch_wait,
  input  logic [NUM_CH-1:0]      ch_ready,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic                   err_clear,
  output logic                   err_collision,
  output logic                   err_timeout,
  output logic [2:0]             last_ch
);

  typedef enum logic [1:0] {
    IDLE, BUSY, RESP, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic              active;
  logic [NUM_CH-1:0] rdy_en;
  logic              any_rdy;
  logic [3:0]        n_rdy;
  logic [2:0]        win_idx;
  logic              win_wr;
  logic [31:0]       win_rd;
  logic              capture;
  logic              expire;
  logic              to_fire;

  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic [31:0]       rd_q, rd_d;
  logic [2:0]        last_q, last_d;
  logic              coll_q, coll_d;

  assign ch_insn = pcpi_insn_in;
  assign ch_rs1  = pcpi_rs1_in;
  assign ch_rs2  = pcpi_rs2_in;
  assign rdy_en  = ch_ready & ch_enable;
  assign any_rdy = |rdy_en;

  // Walk downwards so the lowest enabled index is the final winner.
  always_comb begin
    win_idx = '0;
    win_wr  = 1'b0;
    win_rd  = '0;
    n_rdy   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rdy_en[i]) begin
        win_idx = 3'(i);
        win_wr  = ch_wr[i];
        win_rd  = ch_rd[32*i +: 32];
      end
      n_rdy = n_rdy + 4'(rdy_en[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    to_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pcpi_valid_in) begin
          if (any_rdy) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!pcpi_valid_in) begin
          state_d = IDLE;
        end else if (any_rdy) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (expire) begin
          to_fire = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = DRAIN;
      DRAIN:   if (!pcpi_valid_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active    = (state_q == IDLE) || (state_q == BUSY);
    ch_valid  = (active && pcpi_valid_in) ? ch_enable : '0;
    pcpi_wait = active && (|(ch_wait & ch_enable));
  end

  always_comb begin
    wr_d    = 1'b0;
    rd_d    = rd_q;
    last_d  = last_q;
    ready_d = (state_d == RESP);
    coll_d  = coll_q & ~err_clear;
    if (capture) begin
      wr_d   = win_wr;
      rd_d   = win_rd;
      last_d = win_idx;
      if (n_rdy > 4'd1) coll_d = 1'b1;
    end else if (to_fire) begin
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= '0;
      last_q  <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      last_q  <= last_d;
      coll_q  <= coll_d;
    end
  end

`ifdef PCPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;

  assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so each BUSY entry starts a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (state_q == BUSY) cnt_d = cnt_q + CW'(1);
    tout_d = to_fire | (tout_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign err_timeout = tout_q;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign pcpi_wr       = wr_q;
  assign pcpi_rd       = rd_q;
  assign pcpi_ready    = ready_q;
  assign last_ch       = last_q;
  assign err_collision = coll_q;

endmodule
